// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_pkg
//  Description : Shared definitions for the bus arbiter: arbitration FSM
//                state encoding and the default watchdog limit.
//  Contents    : arb_state_e   - IDLE / GRANT / ABORT / RELEASE
//                DEFAULT_TIMEOUT - default watchdog limit in cycles
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_ABORT   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Returns the first
//                requesting index strictly after last_idx_i, wrapping
//                modulo NUM_MASTERS (last_idx_i itself is the final
//                candidate).
//  Ports       : req_i      - request vector
//                last_idx_i - index granted most recently
//                idx_o      - selected index (valid when any_o)
//                any_o      - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0]         req_i,
    input  logic [$clog2(NUM_MASTERS)-1:0] last_idx_i,
    output logic [$clog2(NUM_MASTERS)-1:0] idx_o,
    output logic                           any_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;
    logic             w_hi_found;

    // Scan downwards so the lowest index in each half wins. The "high" half
    // (indices above last_idx) has priority; the "low" half is the wrap.
    always_comb begin
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_found = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                if (i > int'(last_idx_i)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IDX_W'(i);
                end else begin
                    w_lo_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign idx_o = w_hi_found ? w_hi_idx : w_lo_idx;
    assign any_o = |req_i;

endmodule : rr_pick
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Round-robin Wishbone bus arbiter with outstanding-transfer
//                tracking and a watchdog that aborts a stuck transfer.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                cyc_i, stb_i    - per-master cycle request and strobe
//                stall_i, ack_i, err_i - slave-path handshake
//                clr_timeout_i   - clears the sticky timeout flag
//                gnt_o, gnt_idx_o, gnt_valid_o - registered grant
//                force_err_o     - one-cycle error pulse on watchdog expiry
//                timeout_o       - sticky watchdog-fired flag
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT,
    parameter int MAX_OUTSTANDING = 7
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_MASTERS-1:0]         cyc_i,
    input  logic [NUM_MASTERS-1:0]         stb_i,
    input  logic                           stall_i,
    input  logic                           ack_i,
    input  logic                           err_i,
    input  logic                           clr_timeout_i,
    output logic [NUM_MASTERS-1:0]         gnt_o,
    output logic [$clog2(NUM_MASTERS)-1:0] gnt_idx_o,
    output logic                           gnt_valid_o,
    output logic                           force_err_o,
    output logic                           timeout_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [OUT_W-1:0]       OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [WD_W-1:0]        WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_MASTERS-1:0] GNT_ONE  = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    arb_state_e             state_q;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic [IDX_W-1:0]       gnt_idx_q;
    logic                   gnt_valid_q;
    logic                   force_err_q;
    logic                   timeout_q;
    logic [OUT_W-1:0]       outst_q;
    logic [OUT_W-1:0]       outst_d;
    logic [WD_W-1:0]        wdog_q;
    logic [WD_W-1:0]        wdog_d;
    logic [IDX_W-1:0]       last_idx_q;

    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_any;
    logic                   w_own_cyc;
    logic                   w_accept;
    logic                   w_resp;
    logic                   w_wdog_clr;
    logic                   w_fire;

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_pick (
        .req_i      (cyc_i),
        .last_idx_i (last_idx_q),
        .idx_o      (w_pick_idx),
        .any_o      (w_pick_any)
    );

    always_comb begin
        w_own_cyc  = cyc_i[gnt_idx_q];
        w_accept   = (state_q == ST_GRANT) & stb_i[gnt_idx_q] & ~stall_i;
        w_resp     = ack_i | err_i;

        // Accept and response in the same cycle cancel out.
        outst_d = outst_q;
        if (w_accept && !w_resp && (outst_q != OUT_MAX)) begin
            outst_d = outst_q + 1'b1;
        end else if (!w_accept && w_resp && (outst_q != '0)) begin
            outst_d = outst_q - 1'b1;
        end

        // The watchdog only runs while something is owed to the master.
        w_wdog_clr = w_accept | w_resp | (outst_q == '0);
        wdog_d     = w_wdog_clr ? '0 : wdog_q + 1'b1;

        // Fire on the edge at which the counter would reach the limit, so the
        // pulse appears TIMEOUT_CYCLES cycles after the last activity.
        w_fire = (state_q == ST_GRANT) & w_own_cyc & ~w_wdog_clr & (wdog_q == WD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            force_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            outst_q     <= '0;
            wdog_q      <= '0;
            last_idx_q  <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            force_err_q <= 1'b0;

            // A coincident fire beats the clear.
            if (w_fire) begin
                timeout_q <= 1'b1;
            end else if (clr_timeout_i) begin
                timeout_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        gnt_q       <= GNT_ONE << w_pick_idx;
                        gnt_idx_q   <= w_pick_idx;
                        gnt_valid_q <= 1'b1;
                        state_q     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!w_own_cyc) begin
                        outst_q     <= '0;
                        wdog_q      <= '0;
                        last_idx_q  <= gnt_idx_q;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (w_fire) begin
                        force_err_q <= 1'b1;
                        outst_q     <= '0;
                        wdog_q      <= '0;
                        state_q     <= ST_ABORT;
                    end else begin
                        outst_q <= outst_d;
                        wdog_q  <= wdog_d;
                    end
                end
                ST_ABORT: begin
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // Grant is kept until the aborted master gives up the bus.
                    if (!w_own_cyc) begin
                        outst_q     <= '0;
                        wdog_q      <= '0;
                        last_idx_q  <= gnt_idx_q;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_valid_o = gnt_valid_q;
    assign force_err_o = force_err_q;
    assign timeout_o   = timeout_q;

endmodule : bus_arbiter
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of requesting bus masters (range 2..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 255: watchdog limit in cycles (range 1..65535).
REQ-003 Parameter MAX_OUTSTANDING, default 7: outstanding-transfer counter saturation limit.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 cyc_i  in  NUM_MASTERS  per-master bus cycle request (wishbone cyc).
REQ-007 stb_i  in  NUM_MASTERS  per-master strobe.
REQ-008 stall_i  in  1  stall from the currently addressed slave path.
REQ-009 ack_i  in  1  ack from the currently addressed slave path.
REQ-010 err_i  in  1  err from the currently addressed slave path.
REQ-011 gnt_o  out  NUM_MASTERS  one-hot grant, registered.
REQ-012 gnt_idx_o  out  clog2(NUM_MASTERS)  index of the granted master, registered.
REQ-013 gnt_valid_o  out  1  high while any master holds the bus.
REQ-014 force_err_o  out  1  one-cycle error pulse to the granted master on watchdog expiry.
REQ-015 timeout_o  out  1  sticky watchdog-fired flag, cleared by clr_timeout_i.
REQ-016 clr_timeout_i  in  1  clears timeout_o.

Function
REQ-017 FSM states: IDLE, GRANT, ABORT, RELEASE.
REQ-018 IDLE: when any cyc_i bit is high, register a grant to the first requesting index strictly after last_idx (wrapping modulo NUM_MASTERS), then enter GRANT; grant is visible exactly 1 cycle after cyc_i rises.
REQ-019 last_idx resets to NUM_MASTERS-1, so the first arbitration favours master 0.
REQ-020 GRANT: the grant holds while cyc_i[gnt_idx_o] is high; requests from other masters never preempt it.
REQ-021 Accepted transfer = stb_i[gnt_idx_o] & ~stall_i in GRANT; outstanding increments on accept, decrements on ack_i|err_i, and is unchanged when both occur in the same cycle.
REQ-022 Outstanding saturates at MAX_OUTSTANDING and never decrements below 0.
REQ-023 The watchdog counter clears on any accept, ack_i, err_i, or outstanding==0; it otherwise increments each cycle while in GRANT.
REQ-024 When the watchdog counter reaches TIMEOUT_CYCLES: enter ABORT, pulse force_err_o for 1 cycle, set timeout_o, and zero outstanding.
REQ-025 ABORT lasts 1 cycle and then enters RELEASE, with the grant held.
REQ-026 In GRANT, when cyc_i[gnt_idx_o] falls, outstanding and the watchdog counter clear, last_idx latches gnt_idx_o, the grant drops (gnt_o=0, gnt_valid_o=0), and the FSM enters IDLE; any new grant follows 1 cycle later.
REQ-027 In RELEASE, the grant holds until cyc_i[gnt_idx_o] falls; the exit is then as in REQ-026.
REQ-028 If clr_timeout_i and a watchdog fire coincide, the set wins.
REQ-029 gnt_idx_o holds its last value while gnt_valid_o is low.
REQ-030 With NUM_MASTERS requests pending continuously, every master is granted within NUM_MASTERS grant periods.

Reset
REQ-031 Assertion of rst_n low, including mid-transfer, asynchronously forces: IDLE; gnt_o=0; gnt_idx_o=0; gnt_valid_o=0; force_err_o=0; timeout_o=0; outstanding=0; watchdog=0; last_idx=NUM_MASTERS-1.
REQ-032 After rst_n deasserts, the first grant requires 1 full clock cycle with cyc_i asserted.

Structure
REQ-033 The arb_state_e enum and DEFAULT_TIMEOUT constant reside in the shared bus package.
REQ-034 Round-robin selection is one combinational sub-module, rr_pick (inputs: request vector, last_idx; outputs: next index, any flag).
REQ-035 bus_intercon consumes gnt_idx_o/gnt_valid_o in place of internal arbitration and ORs force_err_o into the granted master's err.

Verification
REQ-036 After reset, cyc_i=4'b0101 held -> gnt_o=4'b0001 one cycle later; master 0 drops cyc -> the next grant is gnt_o=4'b0100.
REQ-037 All 4 masters request continuously, each drops cyc after 3 cycles of grant -> grant order 0,1,2,3,0 with no master skipped.
REQ-038 Granted master issues 2 accepted strobes and the slave never acks, TIMEOUT_CYCLES=8 -> force_err_o pulses 8 cycles after the last accept, timeout_o=1; master drops cyc -> gnt_valid_o=0 next cycle.
REQ-039 Accept and ack in the same cycle with outstanding=1 -> outstanding stays 1 and the watchdog clears.
REQ-040 rst_n pulsed low mid-GRANT with outstanding=3 -> all outputs reset immediately without waiting for a clock edge; arbitration restarts at master 0.
REQ-041 clr_timeout_i asserted in the fire cycle -> timeout_o=1; asserted the following cycle -> timeout_o=0.
